// File: rtl/spi_master_multi.sv
// SPI master with selectable CPOL/CPHA, several chip selects and programmable
// CSN setup/hold/idle spacing; all timing is counted in half-periods of SCLK.
module spi_master_multi #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 10,
  parameter int N_CS      = 4,
  parameter int LSB_FIRST = 1,
  parameter int CS_SETUP  = 12,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 60,
  localparam int CSW      = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic [N_CS-1:0]   spi_csn,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int HP     = CLK_DIV / 2;
  localparam int TICK_W = (HP > 1) ? $clog2(HP) : 1;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int HCNT_W = 16;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [CSW-1:0]      cs_q, cs_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [N_CS-1:0]     csn_q, csn_d;

  logic                half_end;
  logic                edge_fire;
  logic [HCNT_W-1:0]   edge_idx;
  logic                edge_lead;
  logic [BIT_W-1:0]    edge_bit;

  // Wire position of bit b in the shift order.
  function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] b);
    if (LSB_FIRST != 0) return b;
    else return BIT_W'(DATA_W - 1) - b;
  endfunction

  function automatic logic [N_CS-1:0] csn_decode(input logic [CSW-1:0] sel);
    logic [N_CS-1:0] r;
    r = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (sel == CSW'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign half_end = (tick_q == TICK_W'(HP - 1));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    hcnt_d     = hcnt_q;
    tx_d       = tx_q;
    cs_d       = cs_q;
    mode_d     = mode_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    csn_d      = csn_q;
    edge_fire  = 1'b0;
    edge_idx   = '0;
    edge_lead  = 1'b0;
    edge_bit   = '0;

    if (state_q != IDLE) begin
      tick_d = half_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
        hcnt_d = '0;
        if (start) begin
          state_d    = SETUP;
          tx_d       = tx_data;
          cs_d       = cs_sel;
          mode_d     = mode;
          rx_shift_d = '0;
          sclk_d     = mode[1];
          mosi_d     = tx_data[bit_pos('0)];
          csn_d      = csn_decode(cs_sel);
        end
      end
      SETUP: begin
        if (half_end) begin
          if (hcnt_q == HCNT_W'(CS_SETUP - 1)) begin
            state_d   = SHIFT;
            hcnt_d    = '0;
            sclk_d    = ~sclk_q;
            edge_fire = 1'b1;
            edge_idx  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (hcnt_q == HCNT_W'(2 * DATA_W - 1)) begin
            state_d = HOLD;
            hcnt_d  = '0;
          end else begin
            hcnt_d    = hcnt_q + 1'b1;
            sclk_d    = ~sclk_q;
            edge_fire = 1'b1;
            edge_idx  = hcnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          if (hcnt_q == HCNT_W'(CS_HOLD - 1)) begin
            state_d   = GAP;
            hcnt_d    = '0;
            csn_d     = '1;
            mosi_d    = 1'b0;
            rx_data_d = rx_shift_q;
            done_d    = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        // Leave one tick early so the IDLE cycle completes the CSN-high window.
        if (hcnt_q == HCNT_W'(CS_IDLE - 1) && tick_q == TICK_W'(HP - 2)) begin
          state_d = IDLE;
          hcnt_d  = '0;
          tick_d  = '0;
        end else if (half_end) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Even edge index = leading SCLK edge; CPHA selects which kind samples.
    edge_lead = ~edge_idx[0];
    edge_bit  = BIT_W'(edge_idx >> 1);
    if (edge_fire) begin
      if (edge_lead ^ mode_q[0]) begin
        rx_shift_d[bit_pos(edge_bit)] = spi_miso;
      end else if (mode_q[0] == 1'b0) begin
        if (edge_bit != BIT_W'(DATA_W - 1)) begin
          mosi_d = tx_q[bit_pos(edge_bit + 1'b1)];
        end
      end else if (edge_idx != '0) begin
        mosi_d = tx_q[bit_pos(edge_bit)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      hcnt_q     <= '0;
      tx_q       <= '0;
      cs_q       <= '0;
      mode_q     <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      csn_q      <= '1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      hcnt_q     <= hcnt_d;
      tx_q       <= tx_d;
      cs_q       <= cs_d;
      mode_q     <= mode_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      csn_q      <= csn_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign done     = done_q;
  assign spi_sclk = sclk_q;
  assign spi_csn  = csn_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an MSB-first and an LSB-first instance
// (DATA_W=8, CLK_DIV=4, setup/hold 1, idle 2) driven from a vector table.
`timescale 1ns/1ps
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [1:0] mode;
  logic [2:0] cs_sel;
  logic [7:0] tx_data;
  logic [1:0] miso_src;
  logic       obs_b;

  logic [7:0] rx_a, rx_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       sclk_a, sclk_b, mosi_a, mosi_b, miso_a, miso_b;
  logic [4:0] csn_a, csn_b;

  logic [7:0] o_rx;
  logic       o_busy, o_done, o_sclk, o_mosi;
  logic [4:0] o_csn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // miso_src: 0 = loopback from MOSI, 1 = tied high, 2 = tied low
  assign miso_a = (miso_src == 2'd0) ? mosi_a : (miso_src == 2'd1);
  assign miso_b = (miso_src == 2'd0) ? mosi_b : (miso_src == 2'd1);

  assign o_rx   = obs_b ? rx_b   : rx_a;
  assign o_busy = obs_b ? busy_b : busy_a;
  assign o_done = obs_b ? done_b : done_a;
  assign o_sclk = obs_b ? sclk_b : sclk_a;
  assign o_mosi = obs_b ? mosi_b : mosi_a;
  assign o_csn  = obs_b ? csn_b  : csn_a;

  // N_CS=5 gives a 3-bit select, so CS_SEL 5..7 reach the no-select path.
  spi_master_multi #(
    .DATA_W(8), .CLK_DIV(4), .N_CS(5), .LSB_FIRST(0),
    .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .cs_sel(cs_sel),
    .tx_data(tx_data), .rx_data(rx_a), .busy(busy_a), .done(done_a),
    .spi_sclk(sclk_a), .spi_csn(csn_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  spi_master_multi #(
    .DATA_W(8), .CLK_DIV(4), .N_CS(5), .LSB_FIRST(1),
    .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .cs_sel(cs_sel),
    .tx_data(tx_data), .rx_data(rx_b), .busy(busy_b), .done(done_b),
    .spi_sclk(sclk_b), .spi_csn(csn_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  typedef struct {
    bit         use_b;
    logic [1:0] mode;
    logic [2:0] cs;
    logic [7:0] tx;
    logic [1:0] miso_src;
    logic [7:0] exp_rx;
    logic [4:0] exp_csn;
    int         exp_hi;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transfer; checks timing, edges, chip select, slave-side data and RX.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int         cnt, edges, wait_cnt, mosi_hi;
    logic [7:0] old_rx, slave;
    logic [4:0] csn_and;
    logic       prev_sclk, rx_early, got_done, cpol, cpha;
    cpol  = v.mode[1];
    cpha  = v.mode[0];
    obs_b = v.use_b;
    wait_cnt = 0;
    @(negedge clk);
    while (o_busy && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_output($sformatf("%s idle_before_start", tag), {31'd0, o_busy}, 32'd0);
    old_rx   = o_rx;
    mode     = v.mode;
    cs_sel   = v.cs;
    tx_data  = v.tx;
    miso_src = v.miso_src;
    if (v.use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check_output($sformatf("%s busy_after_accept", tag), {31'd0, o_busy}, 32'd1);
    cnt = 1; edges = 0; mosi_hi = 0; prev_sclk = o_sclk; slave = '0;
    csn_and = '1; rx_early = 1'b0; got_done = 1'b0;
    while (cnt < 200) begin
      csn_and &= o_csn;
      if (o_mosi) mosi_hi++;
      if (o_sclk != prev_sclk) begin
        edges++;
        if ((o_sclk != cpol) ^ cpha)
          slave = v.use_b ? {o_mosi, slave[7:1]} : {slave[6:0], o_mosi};
      end
      prev_sclk = o_sclk;
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (o_rx != old_rx) rx_early = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check_output($sformatf("%s done_seen", tag), {31'd0, got_done}, 32'd1);
    check_output($sformatf("%s done_cycle", tag), cnt, 32'd37);
    check_output($sformatf("%s rx_data", tag), {24'd0, o_rx}, {24'd0, v.exp_rx});
    check_output($sformatf("%s sclk_edges", tag), edges, 32'd16);
    check_output($sformatf("%s csn_asserted", tag), {27'd0, csn_and}, {27'd0, v.exp_csn});
    check_output($sformatf("%s slave_word", tag), {24'd0, slave}, {24'd0, v.tx});
    check_output($sformatf("%s rx_early_change", tag), {31'd0, rx_early}, 32'd0);
    if (v.exp_hi > 0)
      check_output($sformatf("%s mosi_high_cycles", tag), mosi_hi, v.exp_hi);
    @(negedge clk);
    check_output($sformatf("%s done_one_cycle", tag), {31'd0, o_done}, 32'd0);
    check_output($sformatf("%s idle_sclk", tag), {31'd0, o_sclk}, {31'd0, cpol});
    check_output($sformatf("%s idle_csn", tag), {27'd0, o_csn}, 32'h1F);
    check_output($sformatf("%s idle_mosi", tag), {31'd0, o_mosi}, 32'd0);
  endtask

  initial begin
    int         d1, d2, gap_len, n;
    logic [7:0] rx1, rx2;
    logic       gap_done, any_done;

    vecs[0] = '{0, 2'b00, 3'd0, 8'hA5, 2'd0, 8'hA5, 5'h1E, 0};
    vecs[1] = '{0, 2'b11, 3'd2, 8'h5A, 2'd1, 8'hFF, 5'h1B, 0};
    vecs[2] = '{0, 2'b01, 3'd1, 8'hC5, 2'd0, 8'hC5, 5'h1D, 0};
    vecs[3] = '{0, 2'b10, 3'd4, 8'h12, 2'd0, 8'h12, 5'h0F, 0};
    vecs[4] = '{0, 2'b00, 3'd5, 8'h80, 2'd0, 8'h80, 5'h1F, 0};
    vecs[5] = '{0, 2'b11, 3'd3, 8'h6E, 2'd2, 8'h00, 5'h17, 0};
    vecs[6] = '{0, 2'b01, 3'd7, 8'h3B, 2'd0, 8'h3B, 5'h1F, 0};
    vecs[7] = '{1, 2'b01, 3'd0, 8'h01, 2'd0, 8'h01, 5'h1E, 6};
    vecs[8] = '{1, 2'b10, 3'd2, 8'hC5, 2'd0, 8'hC5, 5'h1B, 0};
    vecs[9] = '{1, 2'b11, 3'd6, 8'hD2, 2'd1, 8'hFF, 5'h1F, 0};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 2'b00;
    cs_sel = 3'd0; tx_data = 8'h00; miso_src = 2'd0; obs_b = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      obs_b = (k == 1);
      #1;
      check_output($sformatf("reset%0d rx", k), {24'd0, o_rx}, 32'd0);
      check_output($sformatf("reset%0d busy", k), {31'd0, o_busy}, 32'd0);
      check_output($sformatf("reset%0d done", k), {31'd0, o_done}, 32'd0);
      check_output($sformatf("reset%0d csn", k), {27'd0, o_csn}, 32'h1F);
      check_output($sformatf("reset%0d sclk", k), {31'd0, o_sclk}, 32'd0);
      check_output($sformatf("reset%0d mosi", k), {31'd0, o_mosi}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // START held high: back-to-back transfers, TX change while busy must not leak in.
    obs_b = 1'b0; mode = 2'b00; cs_sel = 3'd0; tx_data = 8'h5C; miso_src = 2'd0;
    start_a = 1'b1;
    @(negedge clk);
    d1 = 0; d2 = 0; gap_len = 0; gap_done = 1'b0; rx1 = '0; rx2 = '0;
    for (n = 1; n < 300; n++) begin
      if (n == 10) tx_data = 8'h99;
      if (done_a) begin
        if (d1 == 0) begin
          d1 = n;
          rx1 = rx_a;
        end else begin
          d2 = n;
          rx2 = rx_a;
          break;
        end
      end
      if (d1 > 0 && !gap_done) begin
        if (csn_a == 5'h1F) gap_len++;
        else gap_done = 1'b1;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    check_output("b2b first_done_cycle", d1, 32'd37);
    check_output("b2b done_spacing", d2 - d1, 32'd40);
    check_output("b2b first_rx", {24'd0, rx1}, 32'h5C);
    check_output("b2b second_rx", {24'd0, rx2}, 32'h99);
    check_output("b2b csn_gap", gap_len, 32'd4);

    // Reset in the middle of SHIFT aborts the transfer.
    repeat (10) @(negedge clk);
    mode = 2'b11; cs_sel = 3'd1; tx_data = 8'hF0; miso_src = 2'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort csn", {27'd0, csn_a}, 32'h1F);
    check_output("abort sclk", {31'd0, sclk_a}, 32'd0);
    check_output("abort busy", {31'd0, busy_a}, 32'd0);
    check_output("abort mosi", {31'd0, mosi_a}, 32'd0);
    check_output("abort rx", {24'd0, rx_a}, 32'd0);
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_done |= done_a;
    end
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      any_done |= done_a;
    end
    check_output("abort no_done", {31'd0, any_done}, 32'd0);
    apply_stimulus('{0, 2'b00, 3'd3, 8'h6B, 2'd0, 8'h6B, 5'h17, 0}, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
